pipeline_controller: RTL and testbench

- Central sequencer for the 5-stage RISC-V pipeline.
- Owns run/pause/step/halt sequencing and turns raw hazard, bubble and branch events into per-stage register enables and flushes.
- Replaces the ad-hoc stall/flush logic in the top-level stage-register process; all stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC are gated by its outputs.
- Also maintains cycle and retired-instruction counters for the VGA debug view.

---
 rtl/pipeline_controller_pkg.sv | 31 +++
 rtl/pipeline_controller_perf_counter.sv | 26 ++
 rtl/pipeline_controller.sv | 150 +++++++++++++++
 tb/tb_pipeline_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared pipeline-control types: sequencer states, per-stage enable/flush pair
// and the single NOP control word loaded by every stage flush.
package pipeline_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam logic [1:0] MEM_NO_OP = 2'b00;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_write;
    logic       is_branch;
  } nop_ctrl_t;

  localparam nop_ctrl_t NOP_CTRL = '{reg_write: 1'b0, mem_write: MEM_NO_OP, is_branch: 1'b0};

  localparam stage_ctrl_t STAGE_OFF = '{en: 1'b0, flush: 1'b0};

endpackage

// File: rtl/pipeline_controller_perf_counter.sv
// Free-running wrap-around event counter with synchronous clear (clear beats inc).
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else if (clear_i) begin
      value_q <= '0;
    end else if (inc_i) begin
      value_q <= value_q + CNT_W'(1);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pipeline_controller.sv
// Central run/pause/step/halt sequencer: turns hazard, bubble and branch events
// into same-cycle stage enables and flushes, and keeps the debug counters.
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             hazard_detected,
  input  logic             insert_bubble,
  input  logic             branch_taken_mem,
  input  logic             wb_valid,
  output logic             pc_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  import pipeline_controller_pkg::*;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [DW-1:0] drainCnt_q, drainCnt_d;
  logic stepReq_q;
  logic stepEdge;
  logic pcEn, wbEn;
  stage_ctrl_t idCtrl, exCtrl, memCtrl;

  assign stepEdge = step_req & ~stepReq_q;

  // A flushed stage still loads (en=1) so the NOP actually lands in the register.
  always_comb begin
    pcEn    = 1'b0;
    wbEn    = 1'b0;
    idCtrl  = STAGE_OFF;
    exCtrl  = STAGE_OFF;
    memCtrl = STAGE_OFF;
    case (state_q)
      ST_RUN, ST_STEP: begin
        pcEn = 1'b1; idCtrl.en = 1'b1; exCtrl.en = 1'b1; memCtrl.en = 1'b1; wbEn = 1'b1;
        if (branch_taken_mem) begin
          idCtrl.flush = 1'b1; exCtrl.flush = 1'b1; memCtrl.flush = 1'b1;
        end else if (insert_bubble) begin
          pcEn = 1'b0; idCtrl.en = 1'b0; exCtrl.en = 1'b0; memCtrl.flush = 1'b1;
        end else if (hazard_detected) begin
          pcEn = 1'b0; idCtrl.en = 1'b0; exCtrl.flush = 1'b1;
        end
      end
      ST_DRAIN: begin
        idCtrl = '{en: 1'b1, flush: 1'b1};
        exCtrl.en = 1'b1; memCtrl.en = 1'b1; wbEn = 1'b1;
        if (branch_taken_mem) begin
          exCtrl.flush = 1'b1; memCtrl.flush = 1'b1;
        end else if (insert_bubble) begin
          idCtrl = STAGE_OFF; exCtrl.en = 1'b0; memCtrl.flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Halt is only acted on in RUN/STEP; decode re-presents it once the pipe moves again.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    if (!start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_DRAIN; drainCnt_d = '0;
          end else if (step_mode) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!step_mode)    state_d = ST_RUN;
          else if (stepEdge) state_d = ST_STEP;
        end
        ST_STEP: begin
          if (halt_req) begin
            state_d = ST_DRAIN; drainCnt_d = '0;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        ST_DRAIN: begin
          if (!insert_bubble) begin
            if (drainCnt_q == DRAIN_LAST) state_d = ST_HALTED;
            else                          drainCnt_d = drainCnt_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      drainCnt_q <= '0;
      stepReq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      stepReq_q  <= step_req;
    end
  end

  logic cntClear, cycInc, instInc;
  assign cntClear = (state_q == ST_IDLE) && start;
  assign cycInc   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign instInc  = wb_valid & wbEn;

  perf_counter #(.CNT_W(CNT_W)) uCycleCnt (
    .clk(clk), .rst(rst), .clear_i(cntClear), .inc_i(cycInc), .value_o(cycle_count)
  );

  perf_counter #(.CNT_W(CNT_W)) uInstretCnt (
    .clk(clk), .rst(rst), .clear_i(cntClear), .inc_i(instInc), .value_o(instret_count)
  );

  assign pc_en     = pcEn;
  assign id_en     = idCtrl.en;
  assign ex_en     = exCtrl.en;
  assign mem_en    = memCtrl.en;
  assign wb_en     = wbEn;
  assign id_flush  = idCtrl.flush;
  assign ex_flush  = exCtrl.flush;
  assign mem_flush = memCtrl.flush;
  assign running   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a behavioural model predicts each
// cycle's outputs, queues them, and they are popped and compared against the DUT.
module tb_pipeline_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, step_mode = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic hazard_detected = 1'b0, insert_bubble = 1'b0, branch_taken_mem = 1'b0, wb_valid = 1'b0;
  logic pc_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, mem_flush, running, halted;
  logic [31:0] cycle_count, instret_count;

  pipeline_controller #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step_req(step_req),
    .halt_req(halt_req), .hazard_detected(hazard_detected), .insert_bubble(insert_bubble),
    .branch_taken_mem(branch_taken_mem), .wb_valid(wb_valid),
    .pc_en(pc_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .running(running), .halted(halted),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_STEP, M_DRAIN, M_HALTED} mstate_t;

  typedef struct {
    logic pc, id, ex, mem, wb, idf, exf, memf, run, hlt;
    logic [31:0] cyc, inst;
  } expect_t;

  expect_t expQ[$];
  mstate_t mState = M_IDLE;
  int mDrain = 0;
  logic mStepPrev = 1'b0;
  logic [31:0] mCyc = 0, mInst = 0;
  int total = 0, bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic expect_t predict();
    expect_t e;
    e = '{pc: 0, id: 0, ex: 0, mem: 0, wb: 0, idf: 0, exf: 0, memf: 0, run: 0, hlt: 0, cyc: mCyc, inst: mInst};
    e.run = (mState == M_RUN) || (mState == M_STEP);
    e.hlt = (mState == M_HALTED);
    if (mState == M_RUN || mState == M_STEP) begin
      if (branch_taken_mem)
        e = '{pc: 1, id: 1, ex: 1, mem: 1, wb: 1, idf: 1, exf: 1, memf: 1, run: 1, hlt: 0, cyc: mCyc, inst: mInst};
      else if (insert_bubble)
        e = '{pc: 0, id: 0, ex: 0, mem: 1, wb: 1, idf: 0, exf: 0, memf: 1, run: 1, hlt: 0, cyc: mCyc, inst: mInst};
      else if (hazard_detected)
        e = '{pc: 0, id: 0, ex: 1, mem: 1, wb: 1, idf: 0, exf: 1, memf: 0, run: 1, hlt: 0, cyc: mCyc, inst: mInst};
      else
        e = '{pc: 1, id: 1, ex: 1, mem: 1, wb: 1, idf: 0, exf: 0, memf: 0, run: 1, hlt: 0, cyc: mCyc, inst: mInst};
    end else if (mState == M_DRAIN) begin
      if (branch_taken_mem)
        e = '{pc: 0, id: 1, ex: 1, mem: 1, wb: 1, idf: 1, exf: 1, memf: 1, run: 0, hlt: 0, cyc: mCyc, inst: mInst};
      else if (insert_bubble)
        e = '{pc: 0, id: 0, ex: 0, mem: 1, wb: 1, idf: 0, exf: 0, memf: 1, run: 0, hlt: 0, cyc: mCyc, inst: mInst};
      else
        e = '{pc: 0, id: 1, ex: 1, mem: 1, wb: 1, idf: 1, exf: 0, memf: 0, run: 0, hlt: 0, cyc: mCyc, inst: mInst};
    end
    return e;
  endfunction

  task automatic modelAdvance(input logic wbEnExp);
    logic stepRise;
    stepRise = step_req & ~mStepPrev;
    if (mState == M_IDLE && start) begin
      mCyc = 0;
      mInst = 0;
    end else begin
      if (mState inside {M_RUN, M_STEP, M_DRAIN}) mCyc = mCyc + 1;
      if (wb_valid && wbEnExp) mInst = mInst + 1;
    end
    if (!start) mState = M_IDLE;
    else begin
      case (mState)
        M_IDLE:   mState = M_RUN;
        M_RUN:    if (halt_req) begin mState = M_DRAIN; mDrain = 0; end
                  else if (step_mode) mState = M_PAUSED;
        M_PAUSED: if (!step_mode) mState = M_RUN;
                  else if (stepRise) mState = M_STEP;
        M_STEP:   if (halt_req) begin mState = M_DRAIN; mDrain = 0; end
                  else mState = M_PAUSED;
        M_DRAIN:  if (!insert_bubble) begin
                    if (mDrain == 3) mState = M_HALTED;
                    else mDrain++;
                  end
        default: ;
      endcase
    end
    mStepPrev = step_req;
  endtask

  // Drives one cycle's inputs (called at negedge) and queues the predicted outputs.
  task automatic applyStimulus(input logic st, sm, sr, hr, hz, bb, br, wv);
    start = st; step_mode = sm; step_req = sr; halt_req = hr;
    hazard_detected = hz; insert_bubble = bb; branch_taken_mem = br; wb_valid = wv;
    #1;
    expQ.push_back(predict());
  endtask

  task automatic compareCycle(output logic wbEnExp);
    expect_t e;
    e = expQ.pop_front();
    checkOutput("pc_en",     32'(pc_en),     32'(e.pc));
    checkOutput("id_en",     32'(id_en),     32'(e.id));
    checkOutput("ex_en",     32'(ex_en),     32'(e.ex));
    checkOutput("mem_en",    32'(mem_en),    32'(e.mem));
    checkOutput("wb_en",     32'(wb_en),     32'(e.wb));
    checkOutput("id_flush",  32'(id_flush),  32'(e.idf));
    checkOutput("ex_flush",  32'(ex_flush),  32'(e.exf));
    checkOutput("mem_flush", 32'(mem_flush), 32'(e.memf));
    checkOutput("running",   32'(running),   32'(e.run));
    checkOutput("halted",    32'(halted),    32'(e.hlt));
    checkOutput("cycle_count",   cycle_count,   e.cyc);
    checkOutput("instret_count", instret_count, e.inst);
    wbEnExp = e.wb;
  endtask

  task automatic runCycle(input logic st, sm, sr, hr, hz, bb, br, wv);
    logic wbEnExp;
    applyStimulus(st, sm, sr, hr, hz, bb, br, wv);
    compareCycle(wbEnExp);
    @(posedge clk);
    modelAdvance(wbEnExp);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_en"},    32'({pc_en, id_en, ex_en, mem_en, wb_en}), 32'd0);
    checkOutput({tag, "_flush"}, 32'({id_flush, ex_flush, mem_flush}),      32'd0);
    checkOutput({tag, "_stat"},  32'({running, halted}),                    32'd0);
    checkOutput({tag, "_cyc"},   cycle_count,                               32'd0);
    checkOutput({tag, "_inst"},  instret_count,                             32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wvCount;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    runCycle(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle(0, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);

    wvCount = 0;
    for (int i = 0; i < 10; i++) begin
      runCycle(1, 0, 0, 0, 0, 0, 0, (i % 3) != 0);
      if ((i % 3) != 0) wvCount++;
    end
    checkOutput("cyc_after10",  cycle_count,   32'd10);
    checkOutput("inst_after10", instret_count, 32'(wvCount));

    runCycle(1, 0, 0, 0, 1, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 1, 1, 1);
    runCycle(1, 0, 0, 0, 0, 1, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 1, 0);
    runCycle(1, 0, 0, 0, 1, 1, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);

    runCycle(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) runCycle(1, 1, 0, 0, 0, 0, 0, 1);
    runCycle(1, 1, 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      runCycle(1, 1, 1, 0, 0, 0, 0, 1);
      runCycle(1, 1, 0, 0, 0, 0, 0, 1);
      runCycle(1, 1, 0, 0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 5; i++) runCycle(1, 1, 1, 0, 0, 0, 0, 1);
    runCycle(1, 1, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);

    runCycle(1, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) runCycle(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) runCycle(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle(0, 0, 0, 0, 0, 0, 0, 1);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);

    runCycle(1, 0, 0, 1, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 1, 1);
    runCycle(1, 0, 0, 0, 0, 1, 0, 1);
    runCycle(1, 0, 0, 0, 0, 1, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);

    #2;
    rst = 1'b0;
    #1;
    checkAllZero("midDrainReset");
    @(posedge clk);
    @(negedge clk);
    checkAllZero("heldReset");
    rst = 1'b1;
    mState = M_IDLE; mDrain = 0; mStepPrev = 1'b0; mCyc = 0; mInst = 0;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    runCycle(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
